// File: rtl/ledcomm_rx_decoder_pkg.sv
// Shared Ledcomm receive definitions: pulse-class thresholds, link/timeout defaults,
// pulse-class encodings and the width classifier used by the decoder.
package ledcomm_rx_decoder_pkg;

  localparam int unsigned RUN_W  = 4;
  localparam int unsigned WORD_W = 16;

  localparam logic [RUN_W-1:0] ONE_MIN   = 4'd3;
  localparam logic [RUN_W-1:0] ZERO_MIN  = 4'd7;
  localparam logic [RUN_W-1:0] END_MIN   = 4'd11;
  localparam logic [RUN_W-1:0] ERROR_MIN = 4'd15;
  localparam logic [RUN_W-1:0] RUN_MAX   = 4'd15;

  localparam int unsigned LINK_PULSES_DEF = 18;
  localparam int unsigned TIMEOUT_DEF     = 32;
  localparam int unsigned FIFO_DEPTH_DEF  = 4;

  typedef enum logic [2:0] {
    PC_GLITCH = 3'd0,
    PC_ONE    = 3'd1,
    PC_ZERO   = 3'd2,
    PC_END    = 3'd3,
    PC_ERROR  = 3'd4
  } pulse_class_e;

  function automatic pulse_class_e classify_pulse(input logic [RUN_W-1:0] n);
    pulse_class_e pc;
    if (n >= ERROR_MIN)     pc = PC_ERROR;
    else if (n >= END_MIN)  pc = PC_END;
    else if (n >= ZERO_MIN) pc = PC_ZERO;
    else if (n >= ONE_MIN)  pc = PC_ONE;
    else                    pc = PC_GLITCH;
    return pc;
  endfunction

endpackage

// File: rtl/ledcomm_rx_fifo.sv
// Small synchronous first-word-fall-through word FIFO for the Ledcomm receiver.
// DEPTH must be a power of two and at least 2; head reads as zero while empty.
module ledcomm_rx_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             resetq,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;

  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= wdata;
  end

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign rdata = empty ? '0 : mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/ledcomm_rx_decoder.sv
// Passive Ledcomm receiver: measures bright-pulse widths in base ticks and decodes 16-bit words.
// Define LEDCOMM_RX_FIFO_EN to replace the single holding register with a FIFO_DEPTH-word FIFO.
module ledcomm_rx_decoder
  import ledcomm_rx_decoder_pkg::*;
#(
  parameter int unsigned LINK_PULSES = LINK_PULSES_DEF,
  parameter int unsigned TIMEOUT     = TIMEOUT_DEF
`ifdef LEDCOMM_RX_FIFO_EN
  , parameter int unsigned FIFO_DEPTH = FIFO_DEPTH_DEF
`endif
) (
  input  logic              clk,
  input  logic              resetq,
  input  logic              light_in,
  input  logic [15:0]       basiszeit,
  input  logic              rd,
  output logic [WORD_W-1:0] rx_data,
  output logic              valid,
  output logic              link,
  output logic              overrun,
  output logic              err
);

  localparam int unsigned LC_W = $clog2(LINK_PULSES + 1);
  localparam int unsigned DR_W = $clog2(TIMEOUT + 1);
  localparam logic [LC_W-1:0] LINK_MAX = LC_W'(LINK_PULSES);
  localparam logic [DR_W-1:0] TO_MAX   = DR_W'(TIMEOUT);

  logic              light_s1, light_s2;
  logic [15:0]       div_cnt;
  logic              tick;
  logic [RUN_W-1:0]  bright_run;
  logic [DR_W-1:0]   dark_run;
  logic [WORD_W-1:0] shreg;
  logic [LC_W-1:0]   link_cnt;
  logic [LC_W-1:0]   link_inc;
  pulse_class_e      pclass;
  logic              classify_en;
  logic              timeout_hit;
  logic              deliver;

  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) begin
      light_s1 <= 1'b0;
      light_s2 <= 1'b0;
    end else begin
      light_s1 <= light_in;
      light_s2 <= light_s1;
    end
  end

  // Compare against the live basiszeit so a shrinking period wraps immediately.
  assign tick = (div_cnt == '0);

  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) begin
      div_cnt <= '0;
    end else if (basiszeit <= 16'd1 || div_cnt >= basiszeit - 16'd1) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) begin
      bright_run <= '0;
      dark_run   <= '0;
    end else if (tick) begin
      if (light_s2) begin
        if (bright_run != RUN_MAX) bright_run <= bright_run + RUN_W'(1);
        dark_run <= '0;
      end else begin
        if (dark_run != TO_MAX) dark_run <= dark_run + DR_W'(1);
        bright_run <= '0;
      end
    end
  end

  assign pclass      = classify_pulse(bright_run);
  assign classify_en = tick && !light_s2 && (bright_run != '0);
  // Timeout fires on the tick that reaches TIMEOUT and keeps clearing while saturated.
  assign timeout_hit = tick && !light_s2 && (dark_run >= TO_MAX - DR_W'(1));
  assign link        = (link_cnt >= LINK_MAX);
  assign link_inc    = (link_cnt >= LINK_MAX) ? LINK_MAX : link_cnt + LC_W'(1);
  assign deliver     = classify_en && (pclass == PC_END) && link;

  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) begin
      shreg    <= '0;
      link_cnt <= '0;
    end else if (timeout_hit) begin
      shreg    <= '0;
      link_cnt <= '0;
    end else if (classify_en) begin
      case (pclass)
        PC_ONE: begin
          shreg    <= {shreg[WORD_W-2:0], 1'b1};
          link_cnt <= link_inc;
        end
        PC_ZERO: begin
          shreg    <= {shreg[WORD_W-2:0], 1'b0};
          link_cnt <= link_inc;
        end
        PC_END: begin
          shreg    <= '0;
          link_cnt <= link_inc;
        end
        PC_ERROR: begin
          shreg    <= '0;
          link_cnt <= '0;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) err <= 1'b0;
    else         err <= classify_en && (pclass == PC_ERROR);
  end

`ifdef LEDCOMM_RX_FIFO_EN
  logic fifo_full, fifo_empty, pop, push;

  assign pop  = rd && !fifo_empty;
  assign push = deliver && (!fifo_full || pop);

  ledcomm_rx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (WORD_W)
  ) u_fifo (
    .clk    (clk),
    .resetq (resetq),
    .push   (push),
    .pop    (pop),
    .wdata  (shreg),
    .rdata  (rx_data),
    .full   (fifo_full),
    .empty  (fifo_empty)
  );

  assign valid = !fifo_empty;

  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq)                             overrun <= 1'b0;
    else if (deliver && fifo_full && !pop)   overrun <= 1'b1;
    else if (rd)                             overrun <= 1'b0;
  end
`else
  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) begin
      rx_data <= '0;
      valid   <= 1'b0;
      overrun <= 1'b0;
    end else if (deliver) begin
      rx_data <= shreg;
      valid   <= 1'b1;
      if (rd)         overrun <= 1'b0;
      else if (valid) overrun <= 1'b1;
    end else if (rd) begin
      valid   <= 1'b0;
      overrun <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_ledcomm_rx_decoder.sv
// Directed self-checking bench for ledcomm_rx_decoder at basiszeit = 4.
// All stimulus durations are multiples of four cycles so the tick phase stays fixed after reset.
module tb_ledcomm_rx_decoder;

  logic        clk = 1'b0;
  logic        resetq;
  logic        light_in;
  logic [15:0] basiszeit;
  logic        rd;
  logic [15:0] rx_data;
  logic        valid;
  logic        link;
  logic        overrun;
  logic        err;

  int n_chk  = 0;
  int n_pass = 0;

  ledcomm_rx_decoder dut (
    .clk       (clk),
    .resetq    (resetq),
    .light_in  (light_in),
    .basiszeit (basiszeit),
    .rd        (rd),
    .rx_data   (rx_data),
    .valid     (valid),
    .link      (link),
    .overrun   (overrun),
    .err       (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %04h expected %04h", tag, got, exp);
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // n bright ticks followed by d dark ticks
  task automatic pulse(input int n, input int d = 3);
    light_in = 1'b1;
    cycles(4 * n);
    light_in = 1'b0;
    cycles(4 * d);
  endtask

  task automatic send_word(input logic [15:0] v, input int nbits);
    for (int i = nbits - 1; i >= 0; i--) pulse(v[i] ? 4 : 8);
    pulse(12);
  endtask

  task automatic link_up();
    repeat (18) pulse(8);
  endtask

  task automatic do_rd();
    rd = 1'b1;
    cycles(1);
    rd = 1'b0;
    cycles(3);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    resetq    = 1'b0;
    light_in  = 1'b0;
    basiszeit = 16'd4;
    rd        = 1'b0;
    cycles(3);
    check("rst_rx_data", rx_data, 16'h0000);
    check("rst_valid",   valid,   1'b0);
    check("rst_link",    link,    1'b0);
    check("rst_overrun", overrun, 1'b0);
    check("rst_err",     err,     1'b0);
    resetq = 1'b1;
    cycles(8);

    // link-up: END while link is down is counted but not delivered
    repeat (16) pulse(8);
    check("t1_link_16", link, 1'b0);
    pulse(12);
    check("t1_end_nodeliver", valid, 1'b0);
    check("t1_link_17", link, 1'b0);
    pulse(8);
    check("t1_link_18", link, 1'b1);

    // word 1011 -> 0x000B
    pulse(4); pulse(8); pulse(4); pulse(4);
    check("t2_no_early_valid", valid, 1'b0);
    pulse(12);
    check("t2_valid", valid, 1'b1);
    check("t2_data",  rx_data, 16'h000B);
    check("t2_ovr",   overrun, 1'b0);
    do_rd();
    check("t2_rd_valid", valid, 1'b0);

    // END alone with exact latency: visible one cycle after the classifying tick
    light_in = 1'b1;
    cycles(48);
    light_in = 1'b0;
    cycles(4);
    check("t2_lat_early", valid, 1'b0);
    cycles(1);
    check("t2_lat_valid", valid, 1'b1);
    check("t2_lat_data",  rx_data, 16'h0000);
    cycles(7);
    do_rd();

    // boundaries: 2 ignored, 3/6 ONE, 7/10 ZERO, 11 END -> 0b1100
    pulse(2); pulse(3); pulse(6); pulse(7); pulse(10); pulse(11);
    check("t3_bound_valid", valid, 1'b1);
    check("t3_bound_data",  rx_data, 16'h000C);
    do_rd();
    pulse(14);
    check("t3_end14_valid", valid, 1'b1);
    check("t3_end14_data",  rx_data, 16'h0000);
    do_rd();
    light_in = 1'b1;
    cycles(60);
    light_in = 1'b0;
    cycles(4);
    check("t3_err_early", err, 1'b0);
    cycles(1);
    check("t3_err_strobe", err, 1'b1);
    cycles(1);
    check("t3_err_clear", err, 1'b0);
    check("t3_err_link",  link, 1'b0);
    check("t3_err_valid", valid, 1'b0);
    cycles(6);

    // timeout: 31 dark ticks keep link, 32nd drops it
    link_up();
    check("t4_link", link, 1'b1);
    pulse(4);
    cycles(4 * 29);
    check("t4_dark31", link, 1'b1);
    cycles(4);
    check("t4_dark32", link, 1'b0);
    pulse(12);
    check("t4_end_lost", valid, 1'b0);

    link_up();
`ifdef LEDCOMM_RX_FIFO_EN
    for (int k = 1; k <= 5; k++) send_word(16'(k), 3);
    check("t5_fifo_ovr", overrun, 1'b1);
    for (int k = 1; k <= 4; k++) begin
      check("t5_fifo_valid", valid, 1'b1);
      check("t5_fifo_data",  rx_data, 16'(k));
      do_rd();
    end
    check("t5_fifo_empty", valid, 1'b0);
    check("t5_fifo_ovr_clr", overrun, 1'b0);
`else
    send_word(16'h0001, 1);
    check("t5_w1_valid", valid, 1'b1);
    check("t5_w1_ovr",   overrun, 1'b0);
    send_word(16'h0002, 2);
    check("t5_w2_data",  rx_data, 16'h0002);
    check("t5_w2_valid", valid, 1'b1);
    check("t5_w2_ovr",   overrun, 1'b1);
    do_rd();
    check("t5_rd_valid", valid, 1'b0);
    check("t5_rd_ovr",   overrun, 1'b0);
    // rd on the same edge as a delivery: no overrun, new word shown
    send_word(16'h0003, 2);
    check("t5_w3_data", rx_data, 16'h0003);
    pulse(4);
    light_in = 1'b1;
    cycles(48);
    light_in = 1'b0;
    cycles(4);
    rd = 1'b1;
    cycles(1);
    rd = 1'b0;
    check("t5_simul_valid", valid, 1'b1);
    check("t5_simul_data",  rx_data, 16'h0001);
    check("t5_simul_ovr",   overrun, 1'b0);
    cycles(7);
    do_rd();
`endif

    // reset in the middle of the 5th bit of a word
    send_word(16'h0005, 3);
    check("t6_pre_valid", valid, 1'b1);
    repeat (4) pulse(4);
    light_in = 1'b1;
    cycles(8);
    resetq = 1'b0;
    cycles(1);
    check("t6_rst_data",  rx_data, 16'h0000);
    check("t6_rst_valid", valid, 1'b0);
    check("t6_rst_link",  link, 1'b0);
    check("t6_rst_ovr",   overrun, 1'b0);
    check("t6_rst_err",   err, 1'b0);
    light_in = 1'b0;
    cycles(2);
    resetq = 1'b1;
    cycles(8);
    repeat (17) pulse(8);
    check("t6_link_17", link, 1'b0);
    pulse(12);
    check("t6_end_nodeliver", valid, 1'b0);
    check("t6_link_18", link, 1'b1);
    send_word(16'h0005, 3);
    check("t6_resume_valid", valid, 1'b1);
    check("t6_resume_data",  rx_data, 16'h0005);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
